// File: rtl/dm_arbiter_pkg.sv
// rtl/dm_arbiter_pkg.sv - shared types and constants for the DM arbiter
package dm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        CPU  = 1'b0,
        HOST = 1'b1
    } owner_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/dm_arbiter_if.sv
// rtl/dm_arbiter_if.sv - CPU, host and DM signal bundle for dm_arbiter
interface dm_arbiter_if #(
    parameter int AW = 7,
    parameter int DW = 32
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_done;
    logic          cpu_stall;

    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic [DW-1:0] host_rdata;
    logic          host_done;

    logic          dm_en;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  dm_rdata,
        output cpu_rdata, cpu_done, cpu_stall,
        output host_rdata, host_done,
        output dm_en, dm_we, dm_addr, dm_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output dm_rdata,
        input  cpu_rdata, cpu_done, cpu_stall,
        input  host_rdata, host_done,
        input  dm_en, dm_we, dm_addr, dm_wdata
    );

endinterface

// File: rtl/dm_arbiter.sv
// rtl/dm_arbiter.sv - round-robin CPU/host arbiter in front of the single-port DM
// Optional performance counters are enabled with DM_ARB_PERF_EN.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int AW     = 7,
    parameter int DW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    dm_arbiter_if.slave bus
`ifdef DM_ARB_PERF_EN
    ,
    output logic [31:0] perf_cpu_stall,
    output logic [31:0] perf_host_grant
`endif
);

    localparam int LAT = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
    localparam logic [1:0] WAIT_INIT = 2'(LAT - 1);

    // On a tie the requester that did not own the previous access wins.
    function automatic owner_e rr_pick(input logic c_req, input logic h_req, input owner_e last);
        if (c_req && h_req) return (last == CPU) ? HOST : CPU;
        return h_req ? HOST : CPU;
    endfunction

    state_e        state_q;
    owner_e        owner_q;
    owner_e        last_q;
    owner_e        grant;
    logic          we_q;
    logic [1:0]    cnt_q;
    logic [1:0]    cnt_d;
    logic          dm_en_q;
    logic          dm_we_q;
    logic [AW-1:0] dm_addr_q;
    logic [DW-1:0] dm_wdata_q;
    logic          cpu_done_q;
    logic          host_done_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] host_rdata_q;
    logic          any_req;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          finish;

    assign any_req   = bus.cpu_req | bus.host_req;
    assign grant     = rr_pick(bus.cpu_req, bus.host_req, last_q);
    assign sel_we    = (grant == CPU) ? bus.cpu_we    : bus.host_we;
    assign sel_addr  = (grant == CPU) ? bus.cpu_addr  : bus.host_addr;
    assign sel_wdata = (grant == CPU) ? bus.cpu_wdata : bus.host_wdata;
    assign cnt_d     = cnt_q - 2'd1;

    // finish marks the edge that enters RESP; read data is captured on that same edge.
    assign finish = ((state_q == ISSUE) && (we_q || (LAT == 1))) ||
                    ((state_q == WAIT) && (cnt_d == 2'd0));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= CPU;
            last_q       <= HOST;
            we_q         <= 1'b0;
            cnt_q        <= 2'd0;
            dm_en_q      <= 1'b0;
            dm_we_q      <= 1'b0;
            dm_addr_q    <= '0;
            dm_wdata_q   <= '0;
            cpu_done_q   <= 1'b0;
            host_done_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            dm_en_q     <= 1'b0;
            dm_we_q     <= 1'b0;
            cpu_done_q  <= 1'b0;
            host_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q    <= grant;
                        last_q     <= grant;
                        we_q       <= sel_we;
                        dm_addr_q  <= sel_addr;
                        dm_wdata_q <= sel_wdata;
                        dm_en_q    <= 1'b1;
                        dm_we_q    <= sel_we;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (finish) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q   <= WAIT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (finish) state_q <= RESP;
                    cnt_q <= cnt_d;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (finish) begin
                cpu_done_q  <= (owner_q == CPU);
                host_done_q <= (owner_q == HOST);
                if (!we_q) begin
                    if (owner_q == CPU) cpu_rdata_q  <= bus.dm_rdata;
                    else                host_rdata_q <= bus.dm_rdata;
                end
            end
        end
    end

    assign bus.dm_en      = dm_en_q;
    assign bus.dm_we      = dm_we_q;
    assign bus.dm_addr    = dm_addr_q;
    assign bus.dm_wdata   = dm_wdata_q;
    assign bus.cpu_done   = cpu_done_q;
    assign bus.host_done  = host_done_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.host_rdata = host_rdata_q;
    assign bus.cpu_stall  = bus.cpu_req & ~cpu_done_q;

`ifdef DM_ARB_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_stall_d;
    logic [31:0] perf_grant_q;
    logic [31:0] perf_grant_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_grant_d = perf_grant_q;
        if (bus.cpu_req && !cpu_done_q && (perf_stall_q != '1))
            perf_stall_d = perf_stall_q + 32'd1;
        if ((state_q == ISSUE) && (owner_q == HOST) && (perf_grant_q != '1))
            perf_grant_d = perf_grant_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_q <= '0;
            perf_grant_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_grant_q <= perf_grant_d;
        end
    end

    assign perf_cpu_stall  = perf_stall_q;
    assign perf_host_grant = perf_grant_q;
`endif

endmodule
